// File: rtl/nice_hw_deque.sv
// Double-ended queue on a circular buffer with a single command port and
// registered one-cycle responses; CLEAR can optionally scrub storage to zero.
module nice_hw_deque #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned SCRUB_ON_CLEAR = 0,
    localparam int unsigned IDX_W         = $clog2(DEPTH),
    localparam int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [IDX_W-1:0] cmd_index,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] size,
    output logic             empty,
    output logic             full
);

    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [2:0] OP_PUSH_FRONT = 3'd0;
    localparam logic [2:0] OP_PUSH_BACK  = 3'd1;
    localparam logic [2:0] OP_POP_FRONT  = 3'd2;
    localparam logic [2:0] OP_POP_BACK   = 3'd3;
    localparam logic [2:0] OP_GET        = 3'd4;
    localparam logic [2:0] OP_CLEAR      = 3'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SCRUB = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   head, head_n;
    logic [IDX_W-1:0]   tail, tail_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [IDX_W-1:0]   scrub_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               accept;
    logic               is_full;
    logic               is_empty;
    logic               err_c;
    logic [WIDTH-1:0]   rdata_c;
    logic               we_c;
    logic [IDX_W-1:0]   waddr_c;
    logic [WIDTH-1:0]   wdata_c;
    logic [SUM_W-1:0]   get_sum;
    logic               scrubbing;

    // Modulo-DEPTH pointer steps; DEPTH need not be a power of two.
    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] ptr_dec(input logic [IDX_W-1:0] p);
        return (p == '0) ? IDX_W'(DEPTH - 1) : p - IDX_W'(1);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept && (cmd_op == OP_CLEAR) && (SCRUB_ON_CLEAR != 0))
                    state_n = ST_SCRUB;
            end
            ST_SCRUB: begin
                if (scrub_ptr == IDX_W'(DEPTH - 1))
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready = 1'b0;
        scrubbing = 1'b0;
        case (state)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_SCRUB: scrubbing = 1'b1;
            default:  cmd_ready = 1'b0;
        endcase
    end

    assign accept   = cmd_valid && cmd_ready;
    assign is_full  = (count == CNT_W'(DEPTH));
    assign is_empty = (count == '0);

    // Command decode: next pointers, memory write port and response data.
    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        err_c   = 1'b0;
        rdata_c = '0;
        we_c    = 1'b0;
        waddr_c = scrub_ptr;
        wdata_c = '0;
        get_sum = SUM_W'(head) + SUM_W'(cmd_index);
        if (get_sum >= SUM_W'(DEPTH))
            get_sum = get_sum - SUM_W'(DEPTH);

        if (scrubbing) begin
            we_c = 1'b1;
        end else if (accept) begin
            case (cmd_op)
                OP_PUSH_FRONT: begin
                    if (is_full) err_c = 1'b1;
                    else begin
                        head_n  = ptr_dec(head);
                        we_c    = 1'b1;
                        waddr_c = ptr_dec(head);
                        wdata_c = cmd_data;
                        count_n = count + CNT_W'(1);
                    end
                end
                OP_PUSH_BACK: begin
                    if (is_full) err_c = 1'b1;
                    else begin
                        tail_n  = ptr_inc(tail);
                        we_c    = 1'b1;
                        waddr_c = tail;
                        wdata_c = cmd_data;
                        count_n = count + CNT_W'(1);
                    end
                end
                OP_POP_FRONT: begin
                    if (is_empty) err_c = 1'b1;
                    else begin
                        rdata_c = mem[head];
                        head_n  = ptr_inc(head);
                        count_n = count - CNT_W'(1);
                    end
                end
                OP_POP_BACK: begin
                    if (is_empty) err_c = 1'b1;
                    else begin
                        rdata_c = mem[ptr_dec(tail)];
                        tail_n  = ptr_dec(tail);
                        count_n = count - CNT_W'(1);
                    end
                end
                OP_GET: begin
                    if (SUM_W'(cmd_index) >= SUM_W'(count)) err_c = 1'b1;
                    else rdata_c = mem[IDX_W'(get_sum)];
                end
                OP_CLEAR: begin
                    head_n  = '0;
                    tail_n  = '0;
                    count_n = '0;
                end
                default: err_c = 1'b1;
            endcase
        end
    end

    // Pointers, occupancy and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            scrub_ptr <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            head      <= head_n;
            tail      <= tail_n;
            count     <= count_n;
            scrub_ptr <= scrubbing ? ptr_inc(scrub_ptr) : '0;
            rsp_valid <= accept;
            rsp_data  <= accept ? rdata_c : '0;
            rsp_err   <= accept && err_c;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we_c) mem[waddr_c] <= wdata_c;
    end

    assign size  = count;
    assign empty = is_empty;
    assign full  = is_full;

endmodule

// File: tb/tb_nice_hw_deque.sv
// Directed bench for nice_hw_deque: three instances cover the default
// configuration, scrub-on-clear, and a non-power-of-two depth.
module tb_nice_hw_deque;

    localparam logic [2:0] PF  = 3'd0;
    localparam logic [2:0] PB  = 3'd1;
    localparam logic [2:0] OF  = 3'd2;
    localparam logic [2:0] OB  = 3'd3;
    localparam logic [2:0] GT  = 3'd4;
    localparam logic [2:0] CL  = 3'd5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_err, empty, full;
    logic [2:0][2:0] cmd_op, cmd_index, size;
    logic [2:0][7:0] cmd_data, rsp_data;

    int vectors     = 0;
    int miscompares = 0;

    nice_hw_deque #(.WIDTH(8), .DEPTH(4), .SCRUB_ON_CLEAR(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]), .cmd_index(cmd_index[0][1:0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .size(size[0]), .empty(empty[0]), .full(full[0]));

    nice_hw_deque #(.WIDTH(8), .DEPTH(4), .SCRUB_ON_CLEAR(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]), .cmd_index(cmd_index[1][1:0]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .size(size[1]), .empty(empty[1]), .full(full[1]));

    nice_hw_deque #(.WIDTH(8), .DEPTH(5), .SCRUB_ON_CLEAR(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_op(cmd_op[2]), .cmd_data(cmd_data[2]), .cmd_index(cmd_index[2]),
        .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]), .rsp_err(rsp_err[2]),
        .size(size[2]), .empty(empty[2]), .full(full[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [2:0] op, input logic [7:0] data,
                         input logic [2:0] idx);
        @(negedge clk);
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        cmd_data[d]  = data;
        cmd_index[d] = idx;
    endtask

    // One accepted command, checking the response and occupancy just after the edge.
    task automatic cmd(input string tag, input int d, input logic [2:0] op,
                       input logic [7:0] data, input logic [2:0] idx,
                       input logic [7:0] exp_data, input logic exp_err,
                       input logic [2:0] exp_size);
        drive(d, op, data, idx);
        @(posedge clk);
        #1;
        cmd_valid[d] = 1'b0;
        chk({tag, ".valid"}, 32'(rsp_valid[d]), 32'd1);
        chk({tag, ".data"},  32'(rsp_data[d]),  32'(exp_data));
        chk({tag, ".err"},   32'(rsp_err[d]),   32'(exp_err));
        chk({tag, ".size"},  32'(size[d]),      32'(exp_size));
    endtask

    initial begin
        rst_n     = '0;
        cmd_valid = '0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_index = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst.size",  32'(size[0]),      32'd0);
        chk("rst.empty", 32'(empty[0]),     32'd1);
        chk("rst.full",  32'(full[0]),      32'd0);
        chk("rst.ready", 32'(cmd_ready[0]), 32'd1);
        chk("rst.valid", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        rst_n = '1;

        // Mixed-end pushes, indexed reads, pops
        cmd("pb11", 0, PB, 8'h11, 3'd0, 8'h00, 1'b0, 3'd1);
        cmd("pb22", 0, PB, 8'h22, 3'd0, 8'h00, 1'b0, 3'd2);
        cmd("pf33", 0, PF, 8'h33, 3'd0, 8'h00, 1'b0, 3'd3);
        cmd("get0", 0, GT, 8'h00, 3'd0, 8'h33, 1'b0, 3'd3);
        cmd("get2", 0, GT, 8'h00, 3'd2, 8'h22, 1'b0, 3'd3);
        cmd("popb", 0, OB, 8'h00, 3'd0, 8'h22, 1'b0, 3'd2);
        cmd("popf", 0, OF, 8'h00, 3'd0, 8'h33, 1'b0, 3'd1);
        @(posedge clk);
        #1;
        chk("pulse.low", 32'(rsp_valid[0]), 32'd0);

        // Asynchronous reset mid-cycle takes effect without a clock edge
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("arst.size",  32'(size[0]),  32'd0);
        chk("arst.empty", 32'(empty[0]), 32'd1);
        @(negedge clk);
        rst_n[0] = 1'b1;

        // Front push wraps to the last entry; fill and overflow
        cmd("wrap.pf44", 0, PF, 8'h44, 3'd0, 8'h00, 1'b0, 3'd1);
        chk("wrap.mem3", 32'(u_dut0.mem[3]), 32'h44);
        cmd("fill.pb01", 0, PB, 8'h01, 3'd0, 8'h00, 1'b0, 3'd2);
        cmd("fill.pb02", 0, PB, 8'h02, 3'd0, 8'h00, 1'b0, 3'd3);
        cmd("fill.pb03", 0, PB, 8'h03, 3'd0, 8'h00, 1'b0, 3'd4);
        chk("fill.full", 32'(full[0]), 32'd1);
        cmd("ovf.pb55",  0, PB, 8'h55, 3'd0, 8'h00, 1'b1, 3'd4);
        cmd("ovf.pf66",  0, PF, 8'h66, 3'd0, 8'h00, 1'b1, 3'd4);
        cmd("full.get0", 0, GT, 8'h00, 3'd0, 8'h44, 1'b0, 3'd4);
        cmd("full.get3", 0, GT, 8'h00, 3'd3, 8'h03, 1'b0, 3'd4);

        // Non-scrubbing clear and error cases
        cmd("clr",       0, CL, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0);
        chk("clr.ready", 32'(cmd_ready[0]), 32'd1);
        chk("clr.empty", 32'(empty[0]),     32'd1);
        cmd("unf.popf",  0, OF, 8'h00, 3'd0, 8'h00, 1'b1, 3'd0);
        cmd("unf.popb",  0, OB, 8'h00, 3'd0, 8'h00, 1'b1, 3'd0);
        cmd("e.pbA1",    0, PB, 8'hA1, 3'd0, 8'h00, 1'b0, 3'd1);
        cmd("e.pbA2",    0, PB, 8'hA2, 3'd0, 8'h00, 1'b0, 3'd2);
        cmd("e.get2",    0, GT, 8'h00, 3'd2, 8'h00, 1'b1, 3'd2);
        cmd("e.get1",    0, GT, 8'h00, 3'd1, 8'hA2, 1'b0, 3'd2);
        cmd("e.op7",     0, 3'd7, 8'hFF, 3'd0, 8'h00, 1'b1, 3'd2);
        cmd("e.op6",     0, 3'd6, 8'hFF, 3'd0, 8'h00, 1'b1, 3'd2);

        // Scrubbing clear: ready low for four cycles, held command taken on the fifth
        cmd("s.pb01", 1, PB, 8'h01, 3'd0, 8'h00, 1'b0, 3'd1);
        cmd("s.pb02", 1, PB, 8'h02, 3'd0, 8'h00, 1'b0, 3'd2);
        cmd("s.pb03", 1, PB, 8'h03, 3'd0, 8'h00, 1'b0, 3'd3);
        drive(1, CL, 8'h00, 3'd0);
        @(posedge clk);
        #1;
        cmd_op[1]   = PB;
        cmd_data[1] = 8'h77;
        chk("s.clr.valid", 32'(rsp_valid[1]), 32'd1);
        chk("s.clr.err",   32'(rsp_err[1]),   32'd0);
        chk("s.clr.size",  32'(size[1]),      32'd0);
        chk("s.c1.ready",  32'(cmd_ready[1]), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("s.c%0d.ready", k), 32'(cmd_ready[1]), 32'd0);
            chk($sformatf("s.c%0d.valid", k), 32'(rsp_valid[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("s.c5.ready", 32'(cmd_ready[1]), 32'd1);
        chk("s.c5.valid", 32'(rsp_valid[1]), 32'd0);
        chk("s.c5.size",  32'(size[1]),      32'd0);
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        chk("s.held.valid", 32'(rsp_valid[1]), 32'd1);
        chk("s.held.size",  32'(size[1]),      32'd1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("s.mem%0d", k + 1), 32'(u_dut1.mem[k + 1]), 32'd0);

        // Reset during scrub returns to idle immediately
        drive(1, CL, 8'h00, 3'd0);
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        chk("sr.ready0", 32'(cmd_ready[1]), 32'd0);
        @(posedge clk);
        #2;
        rst_n[1] = 1'b0;
        #1;
        chk("sr.ready", 32'(cmd_ready[1]), 32'd1);
        chk("sr.valid", 32'(rsp_valid[1]), 32'd0);
        chk("sr.size",  32'(size[1]),      32'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        cmd("sr.pb66", 1, PB, 8'h66, 3'd0, 8'h00, 1'b0, 3'd1);

        // Depth 5: FIFO order through several pointer wraps
        for (int i = 1; i <= 12; i++) begin
            cmd($sformatf("d5.pb%0d", i), 2, PB, 8'(i), 3'd0, 8'h00, 1'b0, 3'd1);
            cmd($sformatf("d5.pf%0d", i), 2, OF, 8'h00, 3'd0, 8'(i), 1'b0, 3'd0);
        end
        chk("d5.head", 32'(u_dut2.head), 32'd2);
        for (int i = 0; i < 5; i++)
            cmd($sformatf("d5.fill%0d", i), 2, PB, 8'(8'h20 + i), 3'd0, 8'h00, 1'b0, 3'(i + 1));
        chk("d5.full", 32'(full[2]), 32'd1);
        cmd("d5.ovf",  2, PB, 8'h99, 3'd0, 8'h00, 1'b1, 3'd5);
        cmd("d5.get4", 2, GT, 8'h00, 3'd4, 8'h24, 1'b0, 3'd5);
        cmd("d5.popb", 2, OB, 8'h00, 3'd0, 8'h24, 1'b0, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
